// File: rtl/tcm_pkg.sv
// Shared constants for the TCM request-side controller and its response FIFO.
package tcm_pkg;

   localparam int TCM_MEM_SIZE_DEF = 65536;
   localparam int WORD_OFFSET      = 3;
   localparam int RESP_ERR_W       = 1;
   localparam int RESP_DATA_W      = 64;

   function automatic int resp_entry_w(input int tag_w);
      return tag_w + RESP_ERR_W + RESP_DATA_W;
   endfunction

endpackage

// File: rtl/tcm_resp_fifo.sv
// Synchronous FIFO with occupancy output; depth need not be a power of two.
module tcm_resp_fifo #(
   parameter int WIDTH = 69,
   parameter int DEPTH = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      unique case ({push_i, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage has no reset; an entry is only observed after a push wrote it.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/tcm_mem_initiator.sv
// Request-side controller for one TCM RAM port: drives the RAM from tagged
// core requests and returns tagged responses through a back-pressurable FIFO.
module tcm_mem_initiator
   import tcm_pkg::*;
#(
   parameter int TCM_MEM_SIZE = TCM_MEM_SIZE_DEF,
   parameter int RAM_AW       = $clog2(TCM_MEM_SIZE / 8),
   parameter int TAG_W        = 4,
   parameter int RESP_DEPTH   = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_rd_i,
   input  logic [7:0]        req_wr_i,
   input  logic [31:0]       req_addr_i,
   input  logic [63:0]       req_data_i,
   input  logic [TAG_W-1:0]  req_tag_i,
   output logic              req_accept_o,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [TAG_W-1:0]  resp_tag_o,
   output logic [63:0]       resp_data_o,
   output logic              resp_error_o,
   output logic [RAM_AW-1:0] ram_addr_o,
   output logic [63:0]       ram_data_o,
   output logic [7:0]        ram_wr_o,
   input  logic [63:0]       ram_data_i
);

   localparam int ENTRY_W = resp_entry_w(TAG_W);
   localparam int CNT_W   = $clog2(RESP_DEPTH + 1);
   localparam int OCC_W   = CNT_W + 1;

   logic               req_present, in_range, fire;
   logic [CNT_W-1:0]   fifo_count;
   logic [OCC_W-1:0]   occupancy;
   logic [ENTRY_W-1:0] push_entry, head_entry;

   logic               s1_valid_q, s1_valid_d;
   logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
   logic               s1_err_q, s1_err_d;
   logic               s1_rd_q, s1_rd_d;

   assign req_present = req_rd_i || (req_wr_i != 8'h00);
   assign in_range    = req_addr_i < 32'(TCM_MEM_SIZE);
   // Credit counts the in-flight RAM read so a push can never find the FIFO full.
   assign occupancy    = {1'b0, fifo_count} + OCC_W'(s1_valid_q);
   assign req_accept_o = (occupancy < OCC_W'(RESP_DEPTH)) && !rst_i;
   assign fire         = req_present && req_accept_o;

   assign ram_addr_o = req_addr_i[RAM_AW+WORD_OFFSET-1:WORD_OFFSET];
   assign ram_data_o = req_data_i;
   assign ram_wr_o   = (fire && in_range) ? req_wr_i : 8'h00;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      s1_valid_d = fire;
      s1_tag_d   = s1_tag_q;
      s1_err_d   = s1_err_q;
      s1_rd_d    = s1_rd_q;
      if (fire) begin
         s1_tag_d = req_tag_i;
         s1_err_d = !in_range;
         s1_rd_d  = req_rd_i && in_range;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_tag_q   <= '0;
         s1_err_q   <= 1'b0;
         s1_rd_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_tag_q   <= s1_tag_d;
         s1_err_q   <= s1_err_d;
         s1_rd_q    <= s1_rd_d;
      end
   end

   assign push_entry = {s1_tag_q, s1_err_q, (s1_rd_q ? ram_data_i : 64'h0)};

   tcm_resp_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (s1_valid_q),
      .push_data_i (push_entry),
      .pop_i       (resp_valid_o && resp_ready_i),
      .head_o      (head_entry),
      .count_o     (fifo_count)
   );

   // Fields read as zero when empty, which also clears them during reset.
   assign resp_valid_o = (fifo_count != '0);
   assign resp_tag_o   = resp_valid_o ? head_entry[ENTRY_W-1 -: TAG_W] : '0;
   assign resp_error_o = resp_valid_o ? head_entry[RESP_DATA_W] : 1'b0;
   assign resp_data_o  = resp_valid_o ? head_entry[RESP_DATA_W-1:0] : 64'h0;

endmodule
